// File: rtl/serial_add_unit_pkg.sv
// Shared definitions for the digit-serial adder/subtractor:
// controller state encoding and the digit width handled per clock.
package serial_add_unit_pkg;

    // Controller states; the encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits consumed from each operand per RUN cycle.
    localparam int DIGIT_W = 2;

endpackage : serial_add_unit_pkg

// File: rtl/serial_add_unit_add2_slice.sv
// Combinational 2-bit carry slice: a ripple of full-adder cells that adds
// one digit of each operand plus an incoming carry.
module add2_slice
    import serial_add_unit_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               ci,
    output logic [DIGIT_W-1:0] s,
    output logic               co
);

    // carry[i] is the carry into bit i of the digit
    logic [DIGIT_W:0] carry;

    assign carry[0] = ci;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT_W; gi = gi + 1) begin : g_fa
            // One full-adder cell per bit of the digit
            assign s[gi]         = x[gi] ^ y[gi] ^ carry[gi];
            assign carry[gi + 1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign co = carry[DIGIT_W];

endmodule : add2_slice

// File: rtl/serial_add_unit.sv
// Digit-serial WIDTH-bit adder/subtractor. Operands are latched on start and
// consumed 2 bits per clock through a single add2_slice; the result is
// assembled in a shift register and published when the last digit is done.
// Optional build macro SERADD_FLAGS_EN enables the ovf/zero flag logic;
// without it both flag outputs are tied low.
module serial_add_unit
    import serial_add_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    // Number of RUN cycles per operation; derived from WIDTH only.
    localparam int STEPS = WIDTH / DIGIT_W;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    state_t             state_reg;
    logic               ready_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   op_a_reg;
    logic [WIDTH-1:0]   op_b_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               c_out_reg;

    logic [DIGIT_W-1:0] slice_s;
    logic               slice_co;
    logic [WIDTH-1:0]   result_next;
    logic               accept;
    logic               last_step;

    assign accept    = (state_reg == ST_IDLE) && start;
    assign last_step = (state_reg == ST_RUN) && (cnt_reg == LAST_CNT);

    add2_slice u_slice (
        .x  (op_a_reg[DIGIT_W-1:0]),
        .y  (op_b_reg[DIGIT_W-1:0]),
        .ci (carry_reg),
        .s  (slice_s),
        .co (slice_co)
    );

    // The result shift register holds the digits produced so far; the newest
    // digit enters at the top, so after STEPS cycles digit 0 sits at the bottom.
    generate
        if (WIDTH > DIGIT_W) begin : g_acc
            logic [WIDTH-DIGIT_W-1:0] acc_reg;

            assign result_next = {slice_s, acc_reg};

            // Shift each new digit in from the top while running
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (accept) begin
                    acc_reg <= '0;
                end else if (state_reg == ST_RUN) begin
                    acc_reg <= result_next[WIDTH-1:DIGIT_W];
                end
            end
        end else begin : g_no_acc
            assign result_next = slice_s;
        end
    endgenerate

    // Controller FSM with operand shifters, carry, step counter and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_a_reg  <= a;
                        op_b_reg  <= sub ? ~b : b;
                        carry_reg <= sub | c_in;
                        cnt_reg   <= '0;
                        state_reg <= ST_RUN;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    op_a_reg  <= op_a_reg >> DIGIT_W;
                    op_b_reg  <= op_b_reg >> DIGIT_W;
                    carry_reg <= slice_co;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_CNT) begin
                        sum_reg   <= result_next;
                        c_out_reg <= slice_co;
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign sum   = sum_reg;
    assign c_out = c_out_reg;

`ifdef SERADD_FLAGS_EN
    logic a_msb_reg;
    logic b_msb_reg;
    logic ovf_reg;
    logic zero_reg;

    // Capture operand sign bits on accept; evaluate flags with the final digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b0;
        end else if (accept) begin
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
        end else if (last_step) begin
            ovf_reg  <= (a_msb_reg == b_msb_reg) && (slice_s[DIGIT_W-1] != a_msb_reg);
            zero_reg <= (result_next == '0);
        end
    end

    assign ovf  = ovf_reg;
    assign zero = zero_reg;
`else
    // last_step only feeds the flag logic
    logic unused_flags;
    assign unused_flags = last_step;
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule : serial_add_unit

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit at WIDTH=8 (4 digits per operation).
module tb_serial_add_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;
    logic       ovf;
    logic       zero;

    int total = 0;
    int bad   = 0;
    logic [7:0] prev_sum = 8'h00;

    serial_add_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flags only exist when the feature is built in
    function automatic logic flag_exp(input logic f);
`ifdef SERADD_FLAGS_EN
        return f;
`else
        return 1'b0;
`endif
    endfunction

    // One full operation; with noise=1, start and operands toggle during RUN
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                          input logic ts, input logic tc, input logic [7:0] es,
                          input logic ec, input logic eo, input logic ez, input bit noise);
        int  k;
        int  busy_cnt;
        bit  seen;
        @(negedge clk);
        a = ta; b = tbv; sub = ts; c_in = tc; start = 1'b1;
        @(negedge clk);
        chk({tag, "_accept_ready"}, ready, 0);
        if (noise) begin
            start = 1'b1; a = 8'h11; b = 8'h22; sub = ~ts; c_in = ~tc;
        end else begin
            start = 1'b0;
        end
        k = 0; busy_cnt = 0; seen = 0;
        while (!seen && k < 12) begin
            if (k >= 2) start = 1'b0;
            if (done) begin
                seen = 1;
            end else begin
                if (k < 4) chk({tag, "_sum_hold"}, sum, prev_sum);
                if (busy) busy_cnt++;
                @(negedge clk);
                k++;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_latency"}, k, 4);
        chk({tag, "_busy_cycles"}, busy_cnt, 4);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_c_out"}, c_out, ec);
        chk({tag, "_ovf"}, ovf, flag_exp(eo));
        chk({tag, "_zero"}, zero, flag_exp(ez));
        chk({tag, "_busy_in_done"}, busy, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_ready_back"}, ready, 1);
        chk({tag, "_sum_kept"}, sum, es);
        $display("op %s: a=%02h b=%02h sub=%0b c_in=%0b -> sum=%02h c_out=%0b ovf=%0b zero=%0b",
                 tag, ta, tbv, ts, tc, sum, c_out, ovf, zero);
        prev_sum = es;
    endtask

    initial begin
        int  k;
        int  t1;
        int  t2;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; c_in = 1'b0;

        // Reset held for two cycles
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_c_out", c_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 0);
        $display("reset: ready=%0b busy=%0b sum=%02h", ready, busy, sum);

        // Arithmetic cases
        run_op("add",      8'h3C, 8'h25, 0, 0, 8'h61, 0, 0, 0, 0);
        run_op("wrap",     8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1, 0);
        run_op("ovf_add",  8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 0, 0);
        run_op("cin_add",  8'hA5, 8'h5A, 0, 1, 8'h00, 1, 0, 1, 0);
        run_op("sub_ovf",  8'h80, 8'h01, 1, 0, 8'h7F, 1, 1, 0, 0);
        run_op("sub_zero", 8'h05, 8'h05, 1, 0, 8'h00, 1, 0, 1, 0);
        run_op("sub_cin",  8'h05, 8'h03, 1, 1, 8'h02, 1, 0, 0, 0);

        // start and operands wiggling during RUN are ignored
        run_op("ignore",   8'h3C, 8'h25, 0, 0, 8'h61, 0, 0, 0, 1);

        // Reset after two RUN edges: no done, outputs back to reset values
        @(negedge clk);
        a = 8'h10; b = 8'h10; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_sum", sum, 8'h00);
        chk("midrst_c_out", c_out, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_after_done", done, 0);
        chk("midrst_after_ready", ready, 1);
        $display("mid-run reset: ready=%0b sum=%02h", ready, sum);
        prev_sum = 8'h00;
        run_op("post_rst", 8'h10, 8'h10, 0, 0, 8'h20, 0, 0, 0, 0);

        // Back-to-back with start held high
        @(negedge clk);
        a = 8'h01; b = 8'h02; sub = 1'b0; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'h03; b = 8'h04;
        t1 = -1; t2 = -1; k = 0;
        while (t2 < 0 && k < 24) begin
            if (done) begin
                if (t1 < 0) begin
                    t1 = k;
                    chk("b2b_sum1", sum, 8'h03);
                    $display("b2b op1: sum=%02h at k=%0d", sum, k);
                end else begin
                    t2 = k;
                    start = 1'b0;
                    chk("b2b_sum2", sum, 8'h07);
                    $display("b2b op2: sum=%02h at k=%0d", sum, k);
                end
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("b2b_first_latency", t1, 4);
        chk("b2b_spacing", t2 - t1, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_add_unit
